// File: rtl/loader_pkg.sv
// loader_pkg: shared widths and state encoding for the RAM boot loader
package loader_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/loader_index_counter.sv
// loader_index_counter: copy index with sync clear, enable and last-word flag
module loader_index_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] idx,
  output logic         last
);
  logic [W-1:0] idx_q, idx_d;
  always_comb idx_d = clr ? '0 : en ? idx_q + 1'b1 : idx_q;
  always_ff @(posedge clk)
    if (!reset_n) idx_q <= '0;
    else idx_q <= idx_d;
  assign idx  = idx_q;
  assign last = idx_q == limit - 1'b1;
endmodule

// File: rtl/ram_boot_loader.sv
// ram_boot_loader: copies a BROM block into instruction RAM, then hands fetch over to RAM
module ram_boot_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = loader_pkg::ADDR_W,
  parameter int DATA_W = loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] brom_address,
  input  logic [DATA_W-1:0] brom_value,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              execute_from_ram
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d, idx;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic done_q, done_d, cap, last, copying;
  assign copying = state_q == COPY;
  loader_index_counter #(.W(ADDR_W)) u_idx (
    .clk(clk), .reset_n(reset_n), .clr(cap), .en(copying && !last),
    .limit(len_q), .idx(idx), .last(last)
  );
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        cap     = 1'b1;
        state_d = length != '0 ? COPY : DONE;
      end
      COPY:    state_d = last ? DONE : COPY;
      default: state_d = IDLE;
    endcase
    // a zero-length restart from DONE pulses done again, just as from IDLE
    done_d     = state_d == DONE && (state_q != DONE || cap);
    checksum_d = cap ? '0 : copying ? checksum_q ^ brom_value : checksum_q;
    src_d      = cap ? src_base : src_q;
    dst_d      = cap ? dst_base : dst_q;
    len_d      = cap ? length : len_q;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q    <= IDLE;
      checksum_q <= '0;
      done_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      checksum_q <= checksum_d;
      done_q     <= done_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
    end
  assign busy             = copying;
  assign ram_we           = copying;
  assign brom_address     = copying ? src_q + idx : '0;
  assign ram_address      = copying ? dst_q + idx : '0;
  assign ram_wdata        = brom_value;
  assign done             = done_q;
  assign checksum         = checksum_q;
  assign execute_from_ram = state_q == DONE;
endmodule

// File: tb/tb_ram_boot_loader.sv
// tb_ram_boot_loader: scoreboard bench with a word-level copy model and a monitor
module tb_ram_boot_loader;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [15:0] src_base = '0, dst_base = '0, length = '0;
  logic [15:0] brom_address, ram_address;
  logic [31:0] brom_value, ram_wdata, checksum;
  logic ram_we, busy, done, execute_from_ram;
  logic [31:0] brom [0:65535];
  logic [31:0] ram  [0:65535];
  int cyc = 0, checks = 0, errors = 0, writes = 0;

  typedef struct {int cyc; logic [15:0] ba; logic [15:0] ra; logic [31:0] d;} wr_t;
  typedef struct {int cyc; logic [31:0] cs;} dn_t;
  wr_t wq[$];
  dn_t dq[$];
  wr_t w;
  dn_t dn;

  ram_boot_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_base(src_base),
    .dst_base(dst_base), .length(length), .brom_address(brom_address),
    .brom_value(brom_value), .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .busy(busy), .done(done), .checksum(checksum),
    .execute_from_ram(execute_from_ram)
  );

  assign brom_value = brom[brom_address];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        w = wq.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_brom_addr", brom_address, w.ba);
        chk("wr_ram_addr", ram_address, w.ra);
        chk("wr_data", ram_wdata, w.d);
        chk("wr_busy_exe", {busy, execute_from_ram}, 2'b10);
        ram[ram_address] = ram_wdata;
        writes++;
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        dn = dq.pop_front();
        chk("done_cycle", cyc, dn.cyc);
        chk("done_checksum", checksum, dn.cs);
        chk("done_exe_busy", {execute_from_ram, busy}, 2'b10);
      end
    end
  end

  task automatic issue(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                       output logic [31:0] cs);
    @(posedge clk); #1;
    src_base = src; dst_base = dst; length = len; start = 1'b1;
    cs = '0;
    for (int i = 0; i < int'(len); i++) begin
      wq.push_back('{cyc + 1 + i, 16'(src + i), 16'(dst + i), brom[16'(src + i)]});
      cs ^= brom[16'(src + i)];
    end
    dq.push_back('{cyc + int'(len) + 1, cs});
    @(posedge clk); #1;
    start = 1'b0; src_base = 16'($urandom); dst_base = 16'($urandom); length = 16'($urandom);
  endtask

  task automatic run(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                     input bit noise);
    logic [31:0] cs;
    int w0;
    w0 = writes;
    issue(src, dst, len, cs);
    for (int j = 1; j < int'(len) + 6 && dq.size() != 0; j++) begin
      start = (noise && j < int'(len)) ? 1'($urandom) : 1'b0;
      if (start) begin
        src_base = 16'($urandom); dst_base = 16'($urandom); length = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (dq.size() != 0) begin
      chk("done_timeout", dq.size(), 0);
      dq.delete();
    end
    chk("writes_pending", wq.size(), 0);
    wq.delete();
    chk("we_count", writes - w0, len);
    chk("after_done", {execute_from_ram, busy, done, ram_we}, 4'b1000);
    chk("checksum_hold", checksum, cs);
    for (int i = 0; i < int'(len); i++)
      if (ram[16'(dst + i)] !== brom[16'(src + i)])
        chk("ram_image", ram[16'(dst + i)], brom[16'(src + i)]);
  endtask

  task automatic check_idle(input string name);
    chk(name, {ram_we, busy, done, execute_from_ram}, 4'b0000);
    chk({name, "_cs"}, checksum, 0);
    chk({name, "_addr"}, {brom_address, ram_address}, 0);
  endtask

  initial begin
    logic [31:0] cs;
    for (int i = 0; i < 65536; i++) begin
      brom[i] = $urandom;
      ram[i]  = '0;
    end
    brom[16'h10] = 32'hA0A0_0001; brom[16'h11] = 32'h0B0B_0022;
    brom[16'h12] = 32'hC0C0_0333; brom[16'h13] = 32'h0D0D_4444;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_idle("reset");
    run(16'h0010, 16'h0200, 16'd4, 1'b0);
    chk("ram_200", ram[16'h200], 32'hA0A0_0001);
    chk("ram_203", ram[16'h203], 32'h0D0D_4444);
    chk("abcd_checksum", checksum, 32'hA0A0_0001 ^ 32'h0B0B_0022 ^ 32'hC0C0_0333 ^ 32'h0D0D_4444);
    run(16'h1234, 16'h4000, 16'd0, 1'b0);
    run(16'hFFFE, 16'hFFFF, 16'd3, 1'b0);
    run(16'h0300, 16'h5000, 16'd5, 1'b1);
    run(16'h0777, 16'h6000, 16'd2, 1'b0);
    issue(16'h0400, 16'h7000, 16'd8, cs);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    check_idle("mid_reset");
    reset_n = 1'b1;
    wq.delete();
    dq.delete();
    @(posedge clk); #1;
    check_idle("post_reset");
    for (int r = 0; r < 10; r++)
      run(16'($urandom), 16'($urandom), 16'($urandom_range(0, 24)), 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
